pdp8_mem_arbiter: RTL and testbench

Single-port memory arbiter for the PDP-8 core. It shares one synchronous memory port between the instruction fetch/decode unit (IFU read requests) and the execution unit (operand reads and writes). It sits between those two units and the memory model. It sequences every access through a fixed three-cycle request/issue/response cycle and returns data or acknowledge to the winning requester.

---
 rtl/pdp8_mem_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_pdp8_mem_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pdp8_mem_arbiter.sv
// ----------------------------------------------------------------------------
// pdp8_mem_arbiter
//
// Shares one synchronous memory port between the IFU (instruction reads) and
// the EXEC unit (operand reads/writes). Every access walks IDLE -> ISSUE ->
// RESP, so a grant at edge N strobes memory in cycle N+1 and returns the
// response in cycle N+2. EXEC beats IFU; within EXEC a write beats a read.
//
// Optional feature macro: MEM_ARB_STARVE_GUARD_EN
//   When defined, a 3-bit counter tracks EXEC grants made while IFU waits and
//   forces an IFU grant once STARVE_LIMIT of them have happened in a row.
//
// Ports:
//   clk, reset                  clock and synchronous active-high reset
//   ifu_rd_req/addr             IFU read request (held until ifu_rd_valid)
//   ifu_rd_data/valid           IFU read data and one-cycle completion pulse
//   exec_rd_req/exec_wr_req     EXEC read / write request (held until done)
//   exec_addr/exec_wr_data      EXEC address and write data
//   exec_rd_data/valid          EXEC read data and one-cycle completion pulse
//   exec_wr_ack                 EXEC one-cycle write completion pulse
//   mem_rd_req/mem_wr_req       memory strobes (one cycle, mutually exclusive)
//   mem_addr/mem_wr_data        memory address and write data, held from grant
//   mem_rd_data                 memory read data, valid the cycle after strobe
//   arb_err                     sticky protocol error, cleared only by reset
// ----------------------------------------------------------------------------
module pdp8_mem_arbiter #(
    parameter int ADDR_WIDTH   = 12,
    parameter int DATA_WIDTH   = 12,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ifu_rd_req,
    input  logic [ADDR_WIDTH-1:0] ifu_rd_addr,
    output logic [DATA_WIDTH-1:0] ifu_rd_data,
    output logic                  ifu_rd_valid,
    input  logic                  exec_rd_req,
    input  logic                  exec_wr_req,
    input  logic [ADDR_WIDTH-1:0] exec_addr,
    input  logic [DATA_WIDTH-1:0] exec_wr_data,
    output logic [DATA_WIDTH-1:0] exec_rd_data,
    output logic                  exec_rd_valid,
    output logic                  exec_wr_ack,
    output logic                  mem_rd_req,
    output logic                  mem_wr_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  arb_err
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_IFU, OWN_ERD, OWN_EWR} owner_t;

    state_t                  state_q;
    owner_t                  owner_q;
    logic [ADDR_WIDTH-1:0]   mem_addr_q;
    logic [DATA_WIDTH-1:0]   mem_wr_data_q;
    logic                    mem_rd_req_q;
    logic                    mem_wr_req_q;
    logic                    ifu_rd_valid_q;
    logic                    exec_rd_valid_q;
    logic                    exec_wr_ack_q;
    logic                    arb_err_q;

    // Grant decision for the current IDLE cycle
    logic                    grant_vld_d;
    owner_t                  grant_owner_d;
    logic [ADDR_WIDTH-1:0]   grant_addr_d;
    logic                    owner_dropped_d;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam logic [2:0] STARVE_LIM3 = 3'(STARVE_LIMIT);
    logic [2:0] starve_cnt_q;
    logic       starve_force_d;
    assign starve_force_d = ifu_rd_req && (starve_cnt_q == STARVE_LIM3);
`endif

    always_comb begin
        grant_vld_d   = ifu_rd_req | exec_rd_req | exec_wr_req;
        grant_owner_d = OWN_IFU;
        grant_addr_d  = ifu_rd_addr;
        if (exec_wr_req) begin
            grant_owner_d = OWN_EWR;
            grant_addr_d  = exec_addr;
        end else if (exec_rd_req) begin
            grant_owner_d = OWN_ERD;
            grant_addr_d  = exec_addr;
        end
`ifdef MEM_ARB_STARVE_GUARD_EN
        // IFU has waited long enough: it takes this slot over any EXEC request
        if (starve_force_d) begin
            grant_owner_d = OWN_IFU;
            grant_addr_d  = ifu_rd_addr;
        end
`endif
    end

    // A requester that lets go of req while it owns the port is a protocol error
    always_comb begin
        owner_dropped_d = 1'b0;
        case (owner_q)
            OWN_IFU: owner_dropped_d = !ifu_rd_req;
            OWN_ERD: owner_dropped_d = !exec_rd_req;
            OWN_EWR: owner_dropped_d = !exec_wr_req;
            default: owner_dropped_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            owner_q         <= OWN_NONE;
            mem_addr_q      <= '0;
            mem_wr_data_q   <= '0;
            mem_rd_req_q    <= 1'b0;
            mem_wr_req_q    <= 1'b0;
            ifu_rd_valid_q  <= 1'b0;
            exec_rd_valid_q <= 1'b0;
            exec_wr_ack_q   <= 1'b0;
            arb_err_q       <= 1'b0;
        end else begin
            mem_rd_req_q    <= 1'b0;
            mem_wr_req_q    <= 1'b0;
            ifu_rd_valid_q  <= 1'b0;
            exec_rd_valid_q <= 1'b0;
            exec_wr_ack_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_vld_d) begin
                        state_q       <= ISSUE;
                        owner_q       <= grant_owner_d;
                        mem_addr_q    <= grant_addr_d;
                        mem_wr_data_q <= exec_wr_data;
                        mem_rd_req_q  <= (grant_owner_d != OWN_EWR);
                        mem_wr_req_q  <= (grant_owner_d == OWN_EWR);
                        if (exec_rd_req && exec_wr_req) begin
                            arb_err_q <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    state_q         <= RESP;
                    ifu_rd_valid_q  <= (owner_q == OWN_IFU);
                    exec_rd_valid_q <= (owner_q == OWN_ERD);
                    exec_wr_ack_q   <= (owner_q == OWN_EWR);
                    if (owner_dropped_d) begin
                        arb_err_q <= 1'b1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    if (owner_dropped_d) begin
                        arb_err_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef MEM_ARB_STARVE_GUARD_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt_q <= '0;
        end else if (state_q == IDLE) begin
            if (!ifu_rd_req || (grant_vld_d && grant_owner_d == OWN_IFU)) begin
                starve_cnt_q <= '0;
            end else if (grant_vld_d) begin
                starve_cnt_q <= starve_cnt_q + 3'd1;
            end
        end
    end
`endif

    assign mem_addr      = mem_addr_q;
    assign mem_wr_data   = mem_wr_data_q;
    assign mem_rd_req    = mem_rd_req_q;
    assign mem_wr_req    = mem_wr_req_q;
    assign ifu_rd_valid  = ifu_rd_valid_q;
    assign exec_rd_valid = exec_rd_valid_q;
    assign exec_wr_ack   = exec_wr_ack_q;
    assign arb_err       = arb_err_q;
    // Read data is forwarded only during the owner's valid pulse, 0 otherwise
    assign ifu_rd_data   = ifu_rd_valid_q  ? mem_rd_data : '0;
    assign exec_rd_data  = exec_rd_valid_q ? mem_rd_data : '0;

endmodule

// File: tb/tb_pdp8_mem_arbiter.sv
module tb_pdp8_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        ifu_rd_req;
    logic [11:0] ifu_rd_addr;
    logic [11:0] ifu_rd_data;
    logic        ifu_rd_valid;
    logic        exec_rd_req;
    logic        exec_wr_req;
    logic [11:0] exec_addr;
    logic [11:0] exec_wr_data;
    logic [11:0] exec_rd_data;
    logic        exec_rd_valid;
    logic        exec_wr_ack;
    logic        mem_rd_req;
    logic        mem_wr_req;
    logic [11:0] mem_addr;
    logic [11:0] mem_wr_data;
    logic [11:0] mem_rd_data;
    logic        arb_err;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    always #5 clk = ~clk;

    pdp8_mem_arbiter #(.ADDR_WIDTH(12), .DATA_WIDTH(12), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .ifu_rd_req(ifu_rd_req), .ifu_rd_addr(ifu_rd_addr),
        .ifu_rd_data(ifu_rd_data), .ifu_rd_valid(ifu_rd_valid),
        .exec_rd_req(exec_rd_req), .exec_wr_req(exec_wr_req),
        .exec_addr(exec_addr), .exec_wr_data(exec_wr_data),
        .exec_rd_data(exec_rd_data), .exec_rd_valid(exec_rd_valid),
        .exec_wr_ack(exec_wr_ack),
        .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req),
        .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
        .mem_rd_data(mem_rd_data), .arb_err(arb_err)
    );

    // Synchronous memory model with a preload port used during reset
    logic [11:0] mem [0:4095];
    logic        pre_we;
    logic [11:0] pre_addr;
    logic [11:0] pre_data;

    always @(posedge clk) begin
        if (pre_we)
            mem[pre_addr] <= pre_data;
        else if (mem_wr_req)
            mem[mem_addr] <= mem_wr_data;
        if (mem_rd_req)
            mem_rd_data <= mem[mem_addr];
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic preload(input logic [11:0] a, input logic [11:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        tick();
        pre_we = 1'b0;
    endtask

    task automatic test_reset;
        logic [71:0] outs;
        reset = 1'b1;
        tick();
        outs = {mem_rd_req, mem_wr_req, mem_addr, mem_wr_data, ifu_rd_valid, ifu_rd_data,
                exec_rd_valid, exec_rd_data, exec_wr_ack, arb_err};
        n_cmp++;
        if (outs !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h required 0", outs);
        end
        tick();
        n_cmp++;
        if (arb_err !== 1'b0 || mem_rd_req !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_hold: arb_err=%b mem_rd_req=%b required 0/0", arb_err, mem_rd_req);
        end
        reset = 1'b0;
    endtask

    task automatic test_ifu_read;
        ifu_rd_req = 1'b1; ifu_rd_addr = 12'o0200;
        tick();
        ifu_rd_addr = 12'o0000;   // late change must not matter
        n_cmp++;
        if (mem_rd_req !== 1'b1 || mem_wr_req !== 1'b0 || mem_addr !== 12'o0200) begin
            n_bad++;
            $display("FAIL ifu_issue: rd=%b wr=%b addr=%o required 1/0/0200", mem_rd_req, mem_wr_req, mem_addr);
        end
        tick();
        n_cmp++;
        if (ifu_rd_valid !== 1'b1 || ifu_rd_data !== 12'o7402 || mem_rd_req !== 1'b0) begin
            n_bad++;
            $display("FAIL ifu_resp: valid=%b data=%o memrd=%b required 1/7402/0", ifu_rd_valid, ifu_rd_data, mem_rd_req);
        end
        tick();
        ifu_rd_req = 1'b0;
        n_cmp++;
        if (ifu_rd_valid !== 1'b0 || ifu_rd_data !== 12'o0000 || arb_err !== 1'b0) begin
            n_bad++;
            $display("FAIL ifu_after: valid=%b data=%o err=%b required 0/0000/0", ifu_rd_valid, ifu_rd_data, arb_err);
        end
        tick();
    endtask

    task automatic test_priority;
        ifu_rd_req = 1'b1; ifu_rd_addr = 12'o0300;
        exec_wr_req = 1'b1; exec_addr = 12'o0050; exec_wr_data = 12'o1234;
        tick();
        n_cmp++;
        if (mem_wr_req !== 1'b1 || mem_rd_req !== 1'b0 || mem_addr !== 12'o0050 || mem_wr_data !== 12'o1234) begin
            n_bad++;
            $display("FAIL prio_issue: wr=%b rd=%b addr=%o data=%o required 1/0/0050/1234",
                     mem_wr_req, mem_rd_req, mem_addr, mem_wr_data);
        end
        tick();
        n_cmp++;
        if (exec_wr_ack !== 1'b1 || ifu_rd_valid !== 1'b0 || mem[12'o0050] !== 12'o1234) begin
            n_bad++;
            $display("FAIL prio_ack: ack=%b ifuv=%b mem=%o required 1/0/1234", exec_wr_ack, ifu_rd_valid, mem[12'o0050]);
        end
        tick();
        exec_wr_req = 1'b0;
        tick();
        n_cmp++;
        if (mem_rd_req !== 1'b1 || mem_addr !== 12'o0300 || exec_wr_ack !== 1'b0) begin
            n_bad++;
            $display("FAIL prio_ifu_issue: rd=%b addr=%o ack=%b required 1/0300/0", mem_rd_req, mem_addr, exec_wr_ack);
        end
        tick();
        n_cmp++;
        if (ifu_rd_valid !== 1'b1 || ifu_rd_data !== 12'o1111) begin
            n_bad++;
            $display("FAIL prio_ifu_resp: valid=%b data=%o required 1/1111", ifu_rd_valid, ifu_rd_data);
        end
        tick();
        ifu_rd_req = 1'b0;
        tick();
    endtask

    task automatic test_protocol_err;
        exec_rd_req = 1'b1; exec_wr_req = 1'b1; exec_addr = 12'o0060; exec_wr_data = 12'o4321;
        tick();
        n_cmp++;
        if (mem_wr_req !== 1'b1 || mem_rd_req !== 1'b0 || arb_err !== 1'b1) begin
            n_bad++;
            $display("FAIL both_issue: wr=%b rd=%b err=%b required 1/0/1", mem_wr_req, mem_rd_req, arb_err);
        end
        tick();
        n_cmp++;
        if (exec_wr_ack !== 1'b1 || exec_rd_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL both_resp: ack=%b rdv=%b required 1/0", exec_wr_ack, exec_rd_valid);
        end
        tick();
        exec_rd_req = 1'b0; exec_wr_req = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        n_cmp++;
        if (arb_err !== 1'b1 || mem[12'o0060] !== 12'o4321) begin
            n_bad++;
            $display("FAIL err_sticky: err=%b mem=%o required 1/4321", arb_err, mem[12'o0060]);
        end
        do_reset();
        n_cmp++;
        if (arb_err !== 1'b0) begin
            n_bad++;
            $display("FAIL err_clear: err=%b required 0", arb_err);
        end
    endtask

    task automatic test_drop_err;
        ifu_rd_req = 1'b1; ifu_rd_addr = 12'o0200;
        tick();
        ifu_rd_req = 1'b0;
        tick();
        n_cmp++;
        if (ifu_rd_valid !== 1'b1 || ifu_rd_data !== 12'o7402 || arb_err !== 1'b1) begin
            n_bad++;
            $display("FAIL drop_err: valid=%b data=%o err=%b required 1/7402/1", ifu_rd_valid, ifu_rd_data, arb_err);
        end
        tick();
        do_reset();
    endtask

    task automatic test_reset_mid;
        exec_rd_req = 1'b1; exec_addr = 12'o0070;
        tick();
        n_cmp++;
        if (mem_rd_req !== 1'b1 || mem_addr !== 12'o0070) begin
            n_bad++;
            $display("FAIL mid_issue: rd=%b addr=%o required 1/0070", mem_rd_req, mem_addr);
        end
        reset = 1'b1;
        tick();
        n_cmp++;
        if (exec_rd_valid !== 1'b0 || mem_rd_req !== 1'b0 || mem_wr_req !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_abandon: rdv=%b rd=%b wr=%b required 0/0/0", exec_rd_valid, mem_rd_req, mem_wr_req);
        end
        reset = 1'b0;
        tick();
        n_cmp++;
        if (mem_rd_req !== 1'b1 || mem_addr !== 12'o0070 || exec_rd_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_regrant: rd=%b addr=%o rdv=%b required 1/0070/0", mem_rd_req, mem_addr, exec_rd_valid);
        end
        tick();
        n_cmp++;
        if (exec_rd_valid !== 1'b1 || exec_rd_data !== 12'o5555) begin
            n_bad++;
            $display("FAIL mid_resp: rdv=%b data=%o required 1/5555", exec_rd_valid, exec_rd_data);
        end
        tick();
        exec_rd_req = 1'b0;
        tick();
    endtask

    task automatic test_starve;
        logic        exp_ifu;
        logic [11:0] exp_addr;
        exec_rd_req = 1'b1; exec_addr = 12'o0010;
        ifu_rd_req  = 1'b1; ifu_rd_addr = 12'o0400;
        for (int k = 0; k < 8; k++) begin
            exp_ifu  = GUARD && (k == 4);
            exp_addr = exp_ifu ? 12'o0400 : 12'o0010;
            tick();
            n_cmp++;
            if (mem_rd_req !== 1'b1 || mem_addr !== exp_addr) begin
                n_bad++;
                $display("FAIL starve_issue[%0d]: rd=%b addr=%o required 1/%o", k, mem_rd_req, mem_addr, exp_addr);
            end
            tick();
            n_cmp++;
            if (ifu_rd_valid !== exp_ifu || exec_rd_valid !== !exp_ifu) begin
                n_bad++;
                $display("FAIL starve_resp[%0d]: ifuv=%b execv=%b required %b/%b",
                         k, ifu_rd_valid, exec_rd_valid, exp_ifu, !exp_ifu);
            end
            tick();
        end
        exec_rd_req = 1'b0; ifu_rd_req = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        reset = 1'b1;
        ifu_rd_req = 1'b0; ifu_rd_addr = '0;
        exec_rd_req = 1'b0; exec_wr_req = 1'b0; exec_addr = '0; exec_wr_data = '0;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        preload(12'o0200, 12'o7402);
        preload(12'o0300, 12'o1111);
        preload(12'o0070, 12'o5555);
        preload(12'o0400, 12'o0007);
        preload(12'o0010, 12'o0123);
        test_reset();
        test_ifu_read();
        test_priority();
        test_protocol_err();
        test_drop_err();
        test_reset_mid();
        test_starve();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
